// File: rtl/cascade_timer_counter.sv
// Cascaded per-digit-modulus up/down timer counter with IDLE/RUN/DONE run control.
// Optional AUTO_RELOAD_EN: reload the last loaded preset on reaching zero for a periodic timer.
module cascade_timer_counter #(
    parameter int                NDIG   = 4,
    parameter logic [4*NDIG-1:0] MAXVEC = 16'h5959
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [4*NDIG-1:0]   din,
    input  logic                start,
    input  logic                stop,
    input  logic                tick,
    input  logic                up,
    output logic [4*NDIG-1:0]   q,
    output logic                zero,
    output logic                running,
    output logic                done,
    output logic                wrap
);

    localparam int W = 4 * NDIG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   q_next;
    logic [W-1:0]   q_down;
    logic [W-1:0]   q_up;
    logic [W-1:0]   din_clamped;
    logic           carry_out;
    logic           done_next;
    logic           wrap_next;

    // Saturate every digit of a preset to its own maximum.
    function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic [3:0]   dig;
        logic [3:0]   mx;
        res = '0;
        for (int i = 0; i < NDIG; i++) begin
            dig = v[4*i +: 4];
            mx  = MAXVEC[4*i +: 4];
            res[4*i +: 4] = (dig > mx) ? mx : dig;
        end
        return res;
    endfunction

    // Ripple a borrow from digit 0 upward; a digit at 0 reloads its own max.
    function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic [3:0]   dig;
        logic         borrow;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            dig = v[4*i +: 4];
            if (borrow) begin
                if (dig == 4'd0) begin
                    dig = MAXVEC[4*i +: 4];
                end else begin
                    dig    = dig - 4'd1;
                    borrow = 1'b0;
                end
            end
            res[4*i +: 4] = dig;
        end
        return res;
    endfunction

    // Ripple a carry upward; the top bit of the result is the carry out of the last digit.
    function automatic logic [W:0] step_up(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic [3:0]   dig;
        logic         carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            dig = v[4*i +: 4];
            if (carry) begin
                if (dig >= MAXVEC[4*i +: 4]) begin
                    dig = 4'd0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            res[4*i +: 4] = dig;
        end
        return {carry, res};
    endfunction

    assign din_clamped        = clamp_digits(din);
    assign q_down             = step_down(q);
    assign {carry_out, q_up}  = step_up(q);

`ifdef AUTO_RELOAD_EN
    logic [W-1:0] shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= din_clamped;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            done  <= done_next;
            wrap  <= wrap_next;
        end
    end

    // Priority: load > stop > start > tick.
    always_comb begin
        state_next = state;
        q_next     = q;
        done_next  = 1'b0;
        wrap_next  = 1'b0;
        if (load) begin
            q_next     = din_clamped;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !(!up && q == '0)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        if (up) begin
                            q_next    = q_up;
                            wrap_next = carry_out;
                        end else begin
                            q_next = q_down;
                            if (q_down == '0) begin
                                done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                                if (shadow != '0) begin
                                    q_next = shadow;
                                end else begin
                                    state_next = DONE;
                                end
`else
                                state_next = DONE;
`endif
                            end
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign zero    = (q == '0);
    assign running = (state == RUN);

endmodule

// File: tb/tb_cascade_timer_counter.sv
// Directed bench for cascade_timer_counter (NDIG=4, MAXVEC=16'h5959).
module tb_cascade_timer_counter;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] din;
    logic        start;
    logic        stop;
    logic        tick;
    logic        up;
    logic [15:0] q;
    logic        zero;
    logic        running;
    logic        done;
    logic        wrap;

    int total;
    int bad;

    cascade_timer_counter #(.NDIG(4), .MAXVEC(16'h5959)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (din),
        .start   (start),
        .stop    (stop),
        .tick    (tick),
        .up      (up),
        .q       (q),
        .zero    (zero),
        .running (running),
        .done    (done),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: inputs already set are sampled at the edge; outputs observed 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        din  = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        load  = 1'b0;
        din   = '0;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
        up    = 1'b0;
        cyc();
        cyc();
        chk("rst_q", q, 16'h0000);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_zero", zero, 1'b1);
        reset = 1'b0;
        cyc();

        // Down count 0102 -> 0000 across digit borrows
        up = 1'b0;
        do_load(16'h0102);
        chk("t1_load", q, 16'h0102);
        do_start();
        chk("t1_run", running, 1'b1);
        chk("t1_q_after_start", q, 16'h0102);
        tick = 1'b1;
        for (int k = 1; k <= 62; k++) begin
            cyc();
            if (k == 1)  chk("t1_tick1", q, 16'h0101);
            if (k == 2)  chk("t1_tick2", q, 16'h0100);
            if (k == 3)  chk("t1_tick3", q, 16'h0059);
            if (k == 61) begin
                chk("t1_tick61", q, 16'h0001);
                chk("t1_done_early", done, 1'b0);
            end
        end
        chk("t1_q_zero", q, 16'h0000);
        chk("t1_zero", zero, 1'b1);
        chk("t1_done_pulse", done, 1'b1);
        chk("t1_not_running", running, 1'b0);
        cyc();
        chk("t1_done_drop", done, 1'b0);
        for (int k = 0; k < 4; k++) cyc();
        chk("t1_hold_q", q, 16'h0000);
        chk("t1_hold_done", done, 1'b0);
        tick  = 1'b0;
        up    = 1'b1;
        do_start();
        chk("t1_start_in_done", running, 1'b0);

        // Up count with full rollover
        do_load(16'h5958);
        do_start();
        tick = 1'b1;
        cyc();
        chk("t2_q_max", q, 16'h5959);
        chk("t2_wrap_early", wrap, 1'b0);
        cyc();
        chk("t2_q_roll", q, 16'h0000);
        chk("t2_wrap", wrap, 1'b1);
        chk("t2_running", running, 1'b1);
        chk("t2_no_done", done, 1'b0);
        tick = 1'b0;
        cyc();
        chk("t2_wrap_drop", wrap, 1'b0);

        // Clamp on load; load from RUN forces IDLE
        do_load(16'h7A99);
        chk("t3_clamp", q, 16'h5959);
        chk("t3_idle", running, 1'b0);

        // Up carry into a digit with max 5
        do_load(16'h0059);
        do_start();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t3_up_carry", q, 16'h0100);

        // Down borrow through two digits
        up = 1'b0;
        do_load(16'h1000);
        do_start();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t3_dn_borrow", q, 16'h0959);

        // Pause / resume, start+tick together
        do_load(16'h0010);
        do_start();
        tick = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        chk("t4_q7", q, 16'h0007);
        stop = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        stop = 1'b0;
        chk("t4_paused_q", q, 16'h0007);
        chk("t4_paused_run", running, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_start_tick_q", q, 16'h0007);
        chk("t4_start_tick_run", running, 1'b1);
        cyc();
        chk("t4_resume", q, 16'h0006);
        tick = 1'b0;

        // Start refused at zero in down mode; async reset mid-run
        do_load(16'h0000);
        do_start();
        chk("t5_start_zero", running, 1'b0);
        do_load(16'h0030);
        do_start();
        chk("t5_run", running, 1'b1);
        tick  = 1'b1;
        reset = 1'b1;
        #1;
        chk("t5_async_q", q, 16'h0000);
        chk("t5_async_run", running, 1'b0);
        chk("t5_async_done", done, 1'b0);
        cyc();
        reset = 1'b0;
        tick  = 1'b0;
        cyc();
        chk("t5_post_done", done, 1'b0);
        chk("t5_post_q", q, 16'h0000);

`ifdef AUTO_RELOAD_EN
        do_load(16'h0002);
        do_start();
        tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k % 2 == 0) begin
                chk("t6_reload_q", q, 16'h0002);
                chk("t6_done", done, 1'b1);
            end else begin
                chk("t6_mid_q", q, 16'h0001);
                chk("t6_mid_done", done, 1'b0);
            end
            chk("t6_running", running, 1'b1);
        end
        tick = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
